// File: rtl/pe_drain_pkg.sv
// Shared widths, saturation limits and the round/shift/saturate arithmetic
// used by the PE column drain path.
package pe_drain_pkg;

  localparam int IN_W    = 19;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int SAT_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (OUT_W - 1));

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } result_t;

  // Round half toward +inf, arithmetic shift, then clip to the signed OUT_W range.
  function automatic result_t round_shift_sat(input logic [IN_W-1:0]    c,
                                              input logic [SHIFT_W-1:0] shift);
    logic signed [IN_W:0]  c_ext;
    logic signed [IN_W:0]  rnd;
    logic signed [IN_W:0]  sum;
    logic signed [IN_W:0]  r;
    logic signed [IN_W:0]  hi;
    logic signed [IN_W:0]  lo;
    logic [SHIFT_W-1:0]    s;
    result_t               res;
    c_ext = {c[IN_W-1], c};
    s     = (shift > SHIFT_W'(IN_W - 1)) ? SHIFT_W'(IN_W - 1) : shift;
    rnd   = '0;
    if (s != '0) begin
      rnd = (IN_W + 1)'(1) << (s - SHIFT_W'(1));
    end
    sum      = c_ext + rnd;
    r        = sum >>> s;
    hi       = (IN_W + 1)'(SAT_MAX);
    lo       = (IN_W + 1)'(SAT_MIN);
    res.sat  = 1'b0;
    res.data = r[OUT_W-1:0];
    if (r > hi) begin
      res.sat  = 1'b1;
      res.data = OUT_W'(SAT_MAX);
    end else if (r < lo) begin
      res.sat  = 1'b1;
      res.data = OUT_W'(SAT_MIN);
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_col_drain_if.sv
// Bundle of the PE-side input row and the writeback-side ready/valid output.
interface pe_col_drain_if;
  import pe_drain_pkg::*;

  logic [IN_W-1:0]    in_c;
  logic               in_valid;
  logic [SHIFT_W-1:0] in_control_shift;
  logic               in_control_propagate;
  logic [OUT_W-1:0]   out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   fifo_count;
  logic               overflow;

  modport master (
    output in_c, in_valid, in_control_shift, in_control_propagate, out_ready,
    input  out_data, out_sat, out_valid, fifo_count, overflow
  );

  modport slave (
    input  in_c, in_valid, in_control_shift, in_control_propagate, out_ready,
    output out_data, out_sat, out_valid, fifo_count, overflow
  );

endinterface

// File: rtl/drain_fifo.sv
// Synchronous-reset ring buffer with occupancy count; a push into a full
// buffer is only taken when a pop frees a slot on the same edge.
module drain_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe_col_drain.sv
// Drain stage for one systolic column: capture, round/shift/saturate, then
// buffer toward writeback. The column cannot stall, so overflow drops rows.
module pe_col_drain
  import pe_drain_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  pe_col_drain_if.slave  bus
);

  logic               s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]    s1_c_q, s1_c_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic               s2_valid_q, s2_valid_d;
  result_t            s2_res_q, s2_res_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [OUT_W:0]     fifo_rdata;
  logic [CNT_W-1:0]   fifo_cnt;

  // Only drain-phase rows enter; S1 data holds when nothing is accepted.
  always_comb begin
    s1_valid_d = bus.in_valid && bus.in_control_propagate;
    s1_c_d     = s1_c_q;
    s1_shift_d = s1_shift_q;
    if (s1_valid_d) begin
      s1_c_d     = bus.in_c;
      s1_shift_d = bus.in_control_shift;
    end
    s2_valid_d = s1_valid_q;
    s2_res_d   = s2_res_q;
    if (s1_valid_q) begin
      s2_res_d = round_shift_sat(s1_c_q, s1_shift_q);
    end
    fifo_pop   = !fifo_empty && bus.out_ready;
    overflow_d = overflow_q || (s2_valid_q && fifo_full && !fifo_pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_c_q     <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_c_q     <= s1_c_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      overflow_q <= overflow_d;
    end
  end

  drain_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (s2_valid_q),
    .wdata (s2_res_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_data   = fifo_rdata[OUT_W-1:0];
  assign bus.out_sat    = fifo_rdata[OUT_W];
  assign bus.out_valid  = !fifo_empty;
  assign bus.fifo_count = fifo_cnt;
  assign bus.overflow   = overflow_q;

endmodule
